// File: rtl/bicubic_pkg.sv
// Shared bicubic datapath types and default widths.
package bicubic_pkg;

   localparam int LANE_W    = 12;
   localparam int FRAC_BITS = 4;
   localparam int PIX_W     = 8;
   localparam int ADD_LAT   = 2;

   typedef logic signed [LANE_W-1:0] lane_t;
   typedef logic        [PIX_W-1:0]  pixel_t;

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

endpackage

// File: rtl/bicubic_fifo2.sv
// Two-entry registered FIFO. The oldest entry always sits in the head
// register, so the read data is a plain flop output.
module bicubic_fifo2 #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         aresetn,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   output logic [1:0]   count
);

   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic [1:0]   r_count;
   logic         w_wr;
   logic         w_rd;

   // Qualify read/write: reads need data, writes need room unless a read frees it
   always_comb begin
      w_rd = rd_en && (r_count != 2'd0);
      w_wr = wr_en && ((r_count != 2'd2) || w_rd);
   end

   // Storage and occupancy update
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_head  <= {W{1'b0}};
         r_tail  <= {W{1'b0}};
         r_count <= 2'd0;
      end else begin
         case ({w_wr, w_rd})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_head <= wr_data;
               end else begin
                  r_tail <= wr_data;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= wr_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= wr_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rd_data  = r_head;
   assign rd_valid = (r_count != 2'd0);
   assign count    = r_count;

endmodule

// File: rtl/simd_lane_reduce_clamp.sv
// Reduces the four signed lane sums of the INT12 SIMD adder to one clamped
// pixel per cycle, drives the adder clock enable and buffers the result on
// a valid/ready stream. Optional saturation counter: SIMD_REDUCE_SAT_COUNT_EN.
module simd_lane_reduce_clamp
   import bicubic_pkg::*;
#(
   parameter int LANE_W    = bicubic_pkg::LANE_W,
   parameter int FRAC_BITS = bicubic_pkg::FRAC_BITS,
   parameter int PIX_W     = bicubic_pkg::PIX_W,
   parameter int ADD_LAT   = bicubic_pkg::ADD_LAT
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic                     in_valid,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic                     pipe_en,
   input  logic signed [LANE_W-1:0] lane0,
   input  logic signed [LANE_W-1:0] lane1,
   input  logic signed [LANE_W-1:0] lane2,
   input  logic signed [LANE_W-1:0] lane3,
   output logic [PIX_W-1:0]         out_pixel,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     stat_clr,
   output logic [15:0]              sat_count
);

   localparam int SW = LANE_W + 2;
   localparam int RW = LANE_W + 3;
   localparam logic signed [RW-1:0] RND_HALF =
      {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
   localparam logic signed [RW-1:0] PIX_MAX  =
      {{(RW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

   tag_t                  r_tag [ADD_LAT];
   tag_t                  r_s1_tag;
   logic signed [SW-1:0]  r_s01;
   logic signed [SW-1:0]  r_s23;

   logic signed [SW-1:0]  w_sum;
   logic signed [RW-1:0]  w_rnd;
   logic signed [RW-1:0]  w_r;
   logic                  w_clamp_lo;
   logic                  w_clamp_hi;
   logic [PIX_W-1:0]      w_pixel;
   logic                  w_fifo_wr;
   logic                  w_fifo_rd;
   logic [PIX_W:0]        w_fifo_q;
   logic [1:0]            w_fifo_count;

   // Pipe advances only while the output buffer has room; purely register-decoded
   assign pipe_en  = (w_fifo_count != 2'd2);
   assign in_ready = pipe_en;

   // Carry {valid,last} alongside the operands through the adder latency
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         for (int i = 0; i < ADD_LAT; i++) begin
            r_tag[i] <= '{valid: 1'b0, last: 1'b0};
         end
      end else if (pipe_en) begin
         r_tag[0] <= '{valid: in_valid, last: in_last};
         for (int i = 1; i < ADD_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end else begin
         for (int i = 0; i < ADD_LAT; i++) begin
            r_tag[i] <= r_tag[i];
         end
      end
   end

   // S1: pairwise sums of sign-extended lanes
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_s01    <= {SW{1'b0}};
         r_s23    <= {SW{1'b0}};
         r_s1_tag <= '{valid: 1'b0, last: 1'b0};
      end else if (pipe_en) begin
         r_s01    <= {{2{lane0[LANE_W-1]}}, lane0} + {{2{lane1[LANE_W-1]}}, lane1};
         r_s23    <= {{2{lane2[LANE_W-1]}}, lane2} + {{2{lane3[LANE_W-1]}}, lane3};
         r_s1_tag <= r_tag[ADD_LAT-1];
      end else begin
         r_s01    <= r_s01;
         r_s23    <= r_s23;
         r_s1_tag <= r_s1_tag;
      end
   end

   // S2: final sum, round-half-up arithmetic shift and clamp to pixel range
   always_comb begin
      w_sum      = r_s01 + r_s23;
      w_rnd      = {w_sum[SW-1], w_sum} + RND_HALF;
      w_r        = w_rnd >>> FRAC_BITS;
      w_clamp_lo = w_r[RW-1];
      w_clamp_hi = !w_r[RW-1] && (w_r > PIX_MAX);
      if (w_clamp_lo) begin
         w_pixel = {PIX_W{1'b0}};
      end else if (w_clamp_hi) begin
         w_pixel = {PIX_W{1'b1}};
      end else begin
         w_pixel = w_r[PIX_W-1:0];
      end
   end

   assign w_fifo_wr = r_s1_tag.valid && pipe_en;
   assign w_fifo_rd = out_valid && out_ready;

   bicubic_fifo2 #(
      .W (PIX_W + 1)
   ) u_out_fifo (
      .clk      (clk),
      .aresetn  (aresetn),
      .wr_en    (w_fifo_wr),
      .wr_data  ({r_s1_tag.last, w_pixel}),
      .rd_en    (w_fifo_rd),
      .rd_data  (w_fifo_q),
      .rd_valid (out_valid),
      .count    (w_fifo_count)
   );

   assign out_pixel = w_fifo_q[PIX_W-1:0];
   assign out_last  = w_fifo_q[PIX_W];

`ifdef SIMD_REDUCE_SAT_COUNT_EN
   logic [15:0] r_sat_count;

   // Count clamped writes; clear wins over increment, count sticks at max
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_sat_count <= 16'h0000;
      end else if (stat_clr) begin
         r_sat_count <= 16'h0000;
      end else if (w_fifo_wr && (w_clamp_lo || w_clamp_hi) &&
                   (r_sat_count != 16'hFFFF)) begin
         r_sat_count <= r_sat_count + 16'h0001;
      end else begin
         r_sat_count <= r_sat_count;
      end
   end

   assign sat_count = r_sat_count;
`else
   assign sat_count = 16'h0000;
`endif

endmodule
